// File: rtl/counter_sched_pkg.sv
// Shared types and constants for the counter scheduler.
package counter_sched_pkg;

  localparam int DEF_WIDTH = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RUN     = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } state_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr+1 with wrap
// and grants the first requesting index. The pointer lives in the caller.
module rr_arbiter #(
  parameter int N   = 2,
  parameter int IDW = 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] idx
);

  // Priority search starting just after the last granted requester.
  always_comb begin
    logic        found;
    int unsigned pos;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      pos = (32'(ptr) + k) % N;
      if (en && !found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        idx      = IDW'(pos);
      end
    end
  end

endmodule

// File: rtl/counter_sched.sv
// Shares one loadable up-counter between NREQ requesters: round-robin
// grant, load start value, enable for 'steps' cycles, return final count.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = 2,
  parameter int IDW   = id_width(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_start,
  input  logic [NREQ*WIDTH-1:0] req_steps,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_count,
  output logic                  busy,
  output logic                  ctr_load,
  output logic [WIDTH-1:0]      ctr_data,
  output logic                  ctr_enable,
  input  logic [WIDTH-1:0]      ctr_count
);

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   id_q;
  logic [WIDTH-1:0] start_q;
  logic [WIDTH-1:0] rem_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_count_q;

  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_idx;
  logic             arb_en;
  logic             accept;

  // Grants are only offered in IDLE and are suppressed while reset is held.
  assign arb_en = (state_q == IDLE) && rst_;
  assign accept = |gnt;

  rr_arbiter #(
    .N   (NREQ),
    .IDW (IDW)
  ) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .en  (arb_en),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = LOAD;
      LOAD:    state_d = (rem_q != '0) ? RUN : CAPTURE;
      RUN:     if (rem_q == WIDTH'(1)) state_d = CAPTURE;
      CAPTURE: state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; ctr_data is the latched start so it holds between jobs.
  always_comb begin
    req_ready  = gnt;
    busy       = (state_q != IDLE);
    ctr_load   = (state_q == LOAD);
    ctr_enable = (state_q == RUN);
    rsp_valid  = (state_q == RESP);
    ctr_data   = start_q;
    rsp_id     = rsp_id_q;
    rsp_count  = rsp_count_q;
  end

  // Job datapath: latch request at handshake, count down steps, capture result.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      ptr_q       <= IDW'(NREQ - 1);
      id_q        <= '0;
      start_q     <= '0;
      rem_q       <= '0;
      rsp_id_q    <= '0;
      rsp_count_q <= '0;
    end else begin
      if (accept) begin
        ptr_q   <= gnt_idx;
        id_q    <= gnt_idx;
        start_q <= req_start[gnt_idx*WIDTH +: WIDTH];
        rem_q   <= req_steps[gnt_idx*WIDTH +: WIDTH];
      end
      if (state_q == RUN) rem_q <= rem_q - WIDTH'(1);
      if (state_q == CAPTURE) begin
        rsp_count_q <= ctr_count;
        rsp_id_q    <= id_q;
      end
    end
  end

endmodule
